// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      GAP   = 3'd1,
      WAIT  = 3'd2,
      READY = 3'd3,
      FAULT = 3'd4
   } seqState_t;

   localparam int DEF_NUM_STAGES   = 3;
   localparam int DEF_HOLD_CLKS    = 16;
   localparam int DEF_GAP_CLKS     = 8;
   localparam int DEF_TIMEOUT_CLKS = 1024;
   localparam int DEF_CNT_W        = 18;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if ((1 << r) < v) r++;
      return r;
   endfunction

   // A single-stage build still needs a 1-bit index.
   function automatic int idxWidth(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Ordered per-stage reset release with ready handshake, timeout and sticky fault.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES   = DEF_NUM_STAGES,
   parameter int HOLD_CLKS    = DEF_HOLD_CLKS,
   parameter int GAP_CLKS     = DEF_GAP_CLKS,
   parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  resetReq,
   input  logic [NUM_STAGES-1:0] stageReady,
   output logic [NUM_STAGES-1:0] stageReset,
   output logic                  systemReady,
   output logic                  fault,
   output logic                  busy
);

   localparam int IDX_W = idxWidth(NUM_STAGES);

   seqState_t             state, stateNxt;
   logic [CNT_W-1:0]      cnt, cntNxt;
   logic [IDX_W-1:0]      idx, idxNxt;
   logic [NUM_STAGES-1:0] stageResetNxt;
   logic                  curReady;

   always_comb begin
      curReady = 1'b0;
      for (int k = 0; k < NUM_STAGES; k++)
         if (idx == IDX_W'(k)) curReady = stageReady[k];
   end

   always_comb begin
      stateNxt      = state;
      cntNxt        = cnt;
      idxNxt        = idx;
      stageResetNxt = stageReset;
      if (resetReq) begin
         stateNxt      = HOLD;
         cntNxt        = '0;
         idxNxt        = '0;
         stageResetNxt = '1;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == CNT_W'(HOLD_CLKS - 1)) begin
                  stateNxt         = GAP;
                  cntNxt           = '0;
                  stageResetNxt[0] = 1'b0;
               end else cntNxt = cnt + 1'b1;
            end
            GAP: begin
               if (cnt == CNT_W'(GAP_CLKS - 1)) begin
                  stateNxt = WAIT;
                  cntNxt   = '0;
               end else cntNxt = cnt + 1'b1;
            end
            WAIT: begin
               // Ready on the timeout cycle still counts as success.
               if (curReady) begin
                  cntNxt = '0;
                  if (idx == IDX_W'(NUM_STAGES - 1)) stateNxt = READY;
                  else begin
                     stateNxt = GAP;
                     idxNxt   = idx + 1'b1;
                     for (int k = 0; k < NUM_STAGES; k++)
                        if (IDX_W'(k) == idx + 1'b1) stageResetNxt[k] = 1'b0;
                  end
               end else if (cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
                  stateNxt = FAULT;
                  cntNxt   = '0;
               end else cntNxt = cnt + 1'b1;
            end
            READY: if (stageReady != '1) stateNxt = FAULT;
            FAULT: stateNxt = FAULT;
            default: begin
               stateNxt      = HOLD;
               cntNxt        = '0;
               idxNxt        = '0;
               stageResetNxt = '1;
            end
         endcase
      end
      if (stateNxt == FAULT) stageResetNxt = '1;
   end

   // Outputs are registered from next-state so they line up with the state edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= HOLD;
         cnt         <= '0;
         idx         <= '0;
         stageReset  <= '1;
         systemReady <= 1'b0;
         fault       <= 1'b0;
         busy        <= 1'b1;
      end else begin
         state       <= stateNxt;
         cnt         <= cntNxt;
         idx         <= idxNxt;
         stageReset  <= stageResetNxt;
         systemReady <= (stateNxt == READY);
         fault       <= (stateNxt == FAULT);
         busy        <= (stateNxt == HOLD) || (stateNxt == GAP) || (stateNxt == WAIT);
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a small 2-stage configuration.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       resetReq = 1'b0;
   logic [1:0] stageReady = 2'b11;
   logic [1:0] stageReset;
   logic       systemReady, fault, busy;

   int checks = 0;
   int errors = 0;

   reset_sequencer #(
      .NUM_STAGES(2), .HOLD_CLKS(4), .GAP_CLKS(2), .TIMEOUT_CLKS(8), .CNT_W(18)
   ) dut (
      .clk(clk), .reset(reset), .resetReq(resetReq), .stageReady(stageReady),
      .stageReset(stageReset), .systemReady(systemReady), .fault(fault), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; resetReq = 1'b0; stageReady = 2'b11;
      step(); step();
      checks++;
      if (stageReset !== 2'b11 || systemReady !== 1'b0 || fault !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_state got rst=%b rdy=%b flt=%b busy=%b exp rst=11 rdy=0 flt=0 busy=1",
                  stageReset, systemReady, fault, busy);
      end
      checks++;
      if (dut.cnt !== 18'd0) begin
         errors++; $display("FAIL reset_cnt got %0d exp 0", dut.cnt);
      end
   endtask

   task automatic test_nominal();
      logic [1:0] expRst;
      stageReady = 2'b11;
      reset = 1'b0;
      for (int e = 1; e <= 11; e++) begin
         step();
         expRst = (e < 4) ? 2'b11 : (e < 7) ? 2'b10 : 2'b00;
         checks++;
         if (stageReset !== expRst || systemReady !== (e >= 10) || busy !== (e < 10) || fault !== 1'b0) begin
            errors++;
            $display("FAIL nominal edge=%0d got rst=%b rdy=%b busy=%b flt=%b exp rst=%b rdy=%b busy=%b flt=0",
                     e, stageReset, systemReady, busy, fault, expRst, e >= 10, e < 10);
         end
      end
   endtask

   task automatic test_ready_loss();
      stageReady = 2'b10;
      step();
      stageReady = 2'b11;
      checks++;
      if (fault !== 1'b1 || stageReset !== 2'b11 || systemReady !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ready_loss got flt=%b rst=%b rdy=%b busy=%b exp flt=1 rst=11 rdy=0 busy=0",
                  fault, stageReset, systemReady, busy);
      end
      step(); step();
      checks++;
      if (fault !== 1'b1) begin
         errors++; $display("FAIL ready_loss_sticky got flt=%b exp 1", fault);
      end
      resetReq = 1'b1;
      step();
      resetReq = 1'b0;
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1 || stageReset !== 2'b11) begin
         errors++;
         $display("FAIL ready_loss_recover got flt=%b busy=%b rst=%b exp flt=0 busy=1 rst=11",
                  fault, busy, stageReset);
      end
   endtask

   task automatic test_timeout();
      reset = 1'b1; stageReady = 2'b01;
      step();
      reset = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         step();
         if (e == 7) begin
            checks++;
            if (stageReset !== 2'b00) begin
               errors++; $display("FAIL timeout_stage1_release got %b exp 00", stageReset);
            end
         end
      end
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_early edge=16 got flt=%b busy=%b exp flt=0 busy=1", fault, busy);
      end
      step();
      checks++;
      if (fault !== 1'b1 || stageReset !== 2'b11 || busy !== 1'b0 || systemReady !== 1'b0) begin
         errors++;
         $display("FAIL timeout edge=17 got flt=%b rst=%b busy=%b rdy=%b exp flt=1 rst=11 busy=0 rdy=0",
                  fault, stageReset, busy, systemReady);
      end
      stageReady = 2'b11;
      repeat (5) step();
      checks++;
      if (fault !== 1'b1 || stageReset !== 2'b11) begin
         errors++; $display("FAIL timeout_sticky got flt=%b rst=%b exp flt=1 rst=11", fault, stageReset);
      end
      resetReq = 1'b1;
      step();
      resetReq = 1'b0;
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL timeout_recover got flt=%b busy=%b exp flt=0 busy=1", fault, busy);
      end
   endtask

   task automatic test_mid_request();
      reset = 1'b1; stageReady = 2'b11;
      step();
      reset = 1'b0;
      repeat (7) step();
      resetReq = 1'b1;
      step();
      resetReq = 1'b0;
      checks++;
      if (stageReset !== 2'b11 || busy !== 1'b1 || systemReady !== 1'b0) begin
         errors++;
         $display("FAIL mid_request got rst=%b busy=%b rdy=%b exp rst=11 busy=1 rdy=0",
                  stageReset, busy, systemReady);
      end
      for (int e = 1; e <= 4; e++) begin
         step();
         checks++;
         if (stageReset !== ((e < 4) ? 2'b11 : 2'b10)) begin
            errors++;
            $display("FAIL mid_request_hold edge=%0d got %b exp %b", e, stageReset, (e < 4) ? 2'b11 : 2'b10);
         end
      end
   endtask

   task automatic test_held_request();
      logic [1:0] expRst;
      stageReady = 2'b11;
      resetReq = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         checks++;
         if (stageReset !== 2'b11 || dut.cnt !== 18'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL held_request cyc=%0d got rst=%b cnt=%0d busy=%b exp rst=11 cnt=0 busy=1",
                     c, stageReset, dut.cnt, busy);
         end
      end
      resetReq = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         step();
         expRst = (e < 4) ? 2'b11 : (e < 7) ? 2'b10 : 2'b00;
         checks++;
         if (stageReset !== expRst || systemReady !== (e >= 10)) begin
            errors++;
            $display("FAIL held_release edge=%0d got rst=%b rdy=%b exp rst=%b rdy=%b",
                     e, stageReset, systemReady, expRst, e >= 10);
         end
      end
   endtask

   task automatic test_async_reset();
      reset = 1'b1; stageReady = 2'b01;
      step();
      reset = 1'b0;
      repeat (12) step();
      checks++;
      if (stageReset !== 2'b00 || busy !== 1'b1) begin
         errors++; $display("FAIL async_setup got rst=%b busy=%b exp rst=00 busy=1", stageReset, busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (stageReset !== 2'b11 || fault !== 1'b0 || systemReady !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got rst=%b flt=%b rdy=%b busy=%b exp rst=11 flt=0 rdy=0 busy=1",
                  stageReset, fault, systemReady, busy);
      end
      step();
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_ready_loss();
      test_timeout();
      test_mid_request();
      test_held_request();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the debounced, active-high reset request from the front-panel reset debouncer.
- Drives ordered, per-stage reset release to the ALU datapath stages: BCD input capture, ALU core, then 7-seg display driver.
- Asserts every stage reset together. Releases them one at a time. Waits for each stage's ready handshake before releasing the next.
- Reports systemReady, or a sticky fault if a stage never comes ready.

Parameters:
- NUM_STAGES, 3: number of sequenced reset domains; 1..8.
- HOLD_CLKS, 16: minimum cycles all stage resets stay asserted after the request clears.
- GAP_CLKS, 8: settle cycles after a stage's reset is released, before its ready is sampled; >=1.
- TIMEOUT_CLKS, 1024: cycles allowed for stageReady[k] after the gap; >=1.
- CNT_W, 18: counter width; must hold max(HOLD_CLKS, GAP_CLKS, TIMEOUT_CLKS).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high power-on reset.
- resetReq  in  1  debounced reset request (active-high level), same clock domain.
- stageReady  in  NUM_STAGES  per-stage ready; bit k is high when stage k has finished init.
- stageReset  out  NUM_STAGES  per-stage reset, active-high.
- systemReady  out  1  high when all stages are released and ready.
- fault  out  1  sticky stage-timeout / ready-loss flag.
- busy  out  1  high in HOLD, GAP and WAIT.

Behaviour:
- Reset state while reset=1:
  - state=HOLD, cnt=0, idx=0.
  - stageReset all 1; systemReady=0; fault=0; busy=1.
- States: HOLD, GAP, WAIT, READY, FAULT. idx points at the stage currently being released.
- resetReq priority: resetReq=1 in any state overrides everything. Next edge gives HOLD, cnt=0, idx=0, stageReset all 1, systemReady=0, fault=0.
  - While resetReq stays 1, the block remains in HOLD with cnt held at 0.
- HOLD:
  - cnt increments each cycle while resetReq=0.
  - On the edge where cnt==HOLD_CLKS-1: stageReset[0] goes 0, state=GAP, cnt=0.
  - Result: stageReset[0] falls exactly HOLD_CLKS edges after both reset and resetReq are low.
- GAP:
  - stageReady is ignored.
  - On cnt==GAP_CLKS-1: state=WAIT, cnt=0.
- WAIT:
  - If stageReady[idx]=1 and idx<NUM_STAGES-1: idx+1, stageReset[idx+1] goes 0 on the same edge, state=GAP, cnt=0.
  - If stageReady[idx]=1 and idx==NUM_STAGES-1: state=READY, and systemReady=1 from that edge.
  - Else if cnt==TIMEOUT_CLKS-1: state=FAULT.
  - Else cnt+1.
  - If ready arrives on the timeout cycle, ready wins.
- Released stages:
  - A stage's reset, once released, stays released until HOLD or FAULT.
  - stageReady of already-released stages is not rechecked until READY.
- READY:
  - systemReady=1.
  - If any stageReady bit drops to 0, next edge gives FAULT.
- FAULT:
  - All stageReset 1; fault=1; systemReady=0; busy=0.
  - Left only via resetReq=1 or reset.
- Mid-sequence request: resetReq asserted during GAP/WAIT re-asserts already-released stage resets on the next edge; there is no partial release.
- All outputs are registered; no combinational path from inputs to outputs.
- Counter: unsigned CNT_W bits. It never wraps, because every terminal compare resets it.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum encoding: HOLD=0, GAP=1, WAIT=2, READY=3, FAULT=4, 3-bit;
  - default parameter constants;
  - a clog2 helper for idx width.
- Single module; counter and FSM are inline. No sub-module is warranted.

Test Plan (NUM_STAGES=2, HOLD_CLKS=4, GAP_CLKS=2, TIMEOUT_CLKS=8):
- Nominal release:
  - Stimulus: release reset with resetReq=0; stageReady tied 2'b11.
  - Required: stageReset=2'b11 for 4 edges; 2'b10 at edge 4; 2'b00 at edge 7; systemReady=1 at edge 10; busy=0 from edge 10.
- Stage timeout:
  - Stimulus: stageReady=2'b01.
  - Required: stage 1 released at edge 7; WAIT times out 8 edges after the gap; fault=1, stageReset=2'b11 at edge 17; holds until resetReq.
- Request mid-sequence:
  - Stimulus: pulse resetReq=1 during GAP of stage 1.
  - Required: next edge stageReset=2'b11, busy=1, systemReady=0; a full 4-cycle HOLD restarts after resetReq falls.
- Held request:
  - Stimulus: hold resetReq=1 for 20 cycles.
  - Required: stageReset stays 2'b11 and cnt stays 0 throughout; release timing after the drop matches the nominal test.
- Ready loss:
  - Stimulus: in READY, drop stageReady[0] for 1 cycle.
  - Required: FAULT next edge; fault=1; stageReset=2'b11; recovery on resetReq pulse clears fault.
- Async reset:
  - Stimulus: assert reset mid-WAIT between clock edges.
  - Required: stageReset=2'b11, fault=0, systemReady=0 immediately, without waiting for a clk edge.
